match_controller: RTL and testbench

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/match_controller_if.sv | 30 +++
 rtl/match_controller.sv | 129 ++++++++++++
 tb/tb_match_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/match_controller_if.sv
// match_controller_if: delivery inputs and scoreboard outputs of the cricket match controller.
//   master: drives start, ball_valid, ball_outcome; observes all score/result signals
//   slave:  the controller side (receives deliveries, publishes score/result)
interface match_controller_if;
    logic        start;
    logic        ball_valid;
    logic [2:0]  ball_outcome;
    logic [11:0] team1Data;
    logic [11:0] team2Data;
    logic [6:0]  team1Balls;
    logic [6:0]  team2Balls;
    logic [3:0]  wickets;
    logic [7:0]  balls;
    logic        battingTeam;
    logic [2:0]  state;
    logic        ball_accept;
    logic        winner;
    logic        tie;
    logic        winner_valid;
    modport master (
        output start, ball_valid, ball_outcome,
        input  team1Data, team2Data, team1Balls, team2Balls, wickets, balls,
        input  battingTeam, state, ball_accept, winner, tie, winner_valid
    );
    modport slave (
        input  start, ball_valid, ball_outcome,
        output team1Data, team2Data, team1Balls, team2Balls, wickets, balls,
        output battingTeam, state, ball_accept, winner, tie, winner_valid
    );
endinterface

// File: rtl/match_controller.sv
// match_controller: two-innings cricket score keeper and result decider.
//   clk_fpga : system clock, all state changes on rising edge
//   reset    : asynchronous active-low reset
//   bus      : match_controller_if.slave (start/ball_valid/ball_outcome in; per-team
//              {runs,wickets}, balls, batting-team copies, FSM state, ball_accept,
//              winner/tie/winner_valid out)
module match_controller (
    input  logic              clk_fpga,
    input  logic              reset,
    match_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, INN1 = 3'd1, BREAK = 3'd2, INN2 = 3'd3, DONE = 3'd4} state_t;
    state_t     st, st_n;
    logic [7:0] r1, r1_n, r2, r2_n;
    logic [3:0] w1, w1_n, w2, w2_n;
    logic [6:0] b1, b1_n, b2, b2_n;
    logic       acc, acc_n, win, win_n, tie, tie_n, wv, wv_n;
    logic       in2, bt, wk, apply, over;
    logic [7:0] cur_r, nr;
    logic [3:0] cur_w, nw;
    logic [6:0] cur_b, nb;
    logic [8:0] sum;
    assign in2   = st == INN2;
    assign bt    = in2 || st == DONE;
    assign cur_r = in2 ? r2 : r1;
    assign cur_w = in2 ? w2 : w1;
    assign cur_b = in2 ? b2 : b1;
    assign wk    = bus.ball_outcome == 3'd7;
    // Post-delivery values for whichever team is batting; runs saturate at 255.
    assign sum   = {1'b0, cur_r} + {6'd0, bus.ball_outcome};
    assign nr    = wk ? cur_r : (sum[8] ? 8'hff : sum[7:0]);
    assign nw    = (wk && cur_w < 4'd10) ? cur_w + 4'd1 : cur_w;
    assign nb    = cur_b < 7'd120 ? cur_b + 7'd1 : cur_b;
    assign over  = nw == 4'd10 || nb == 7'd120;
    // Start never overlaps an applied ball: start is only honoured outside the innings.
    assign apply = bus.ball_valid && (st == INN1 || in2);
    always_comb begin
        st_n  = st;
        r1_n  = r1;
        w1_n  = w1;
        b1_n  = b1;
        r2_n  = r2;
        w2_n  = w2;
        b2_n  = b2;
        win_n = win;
        tie_n = tie;
        wv_n  = wv;
        acc_n = apply;
        unique case (st)
            IDLE:  st_n = bus.start ? INN1 : IDLE;
            INN1: begin
                if (apply) begin
                    r1_n = nr;
                    w1_n = nw;
                    b1_n = nb;
                    st_n = over ? BREAK : INN1;
                end
            end
            BREAK: st_n = bus.start ? INN2 : BREAK;
            INN2: begin
                if (apply) begin
                    r2_n = nr;
                    w2_n = nw;
                    b2_n = nb;
                    if (over || nr > r1) begin
                        st_n  = DONE;
                        win_n = nr > r1;
                        tie_n = nr == r1;
                        wv_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    st_n  = INN1;
                    r1_n  = '0;
                    w1_n  = '0;
                    b1_n  = '0;
                    r2_n  = '0;
                    w2_n  = '0;
                    b2_n  = '0;
                    win_n = 1'b0;
                    tie_n = 1'b0;
                    wv_n  = 1'b0;
                end
            end
            default: st_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            st  <= IDLE;
            r1  <= '0;
            w1  <= '0;
            b1  <= '0;
            r2  <= '0;
            w2  <= '0;
            b2  <= '0;
            acc <= 1'b0;
            win <= 1'b0;
            tie <= 1'b0;
            wv  <= 1'b0;
        end else begin
            st  <= st_n;
            r1  <= r1_n;
            w1  <= w1_n;
            b1  <= b1_n;
            r2  <= r2_n;
            w2  <= w2_n;
            b2  <= b2_n;
            acc <= acc_n;
            win <= win_n;
            tie <= tie_n;
            wv  <= wv_n;
        end
    end
    assign bus.team1Data    = {r1, w1};
    assign bus.team2Data    = {r2, w2};
    assign bus.team1Balls   = b1;
    assign bus.team2Balls   = b2;
    assign bus.wickets      = bt ? w2 : w1;
    assign bus.balls        = {1'b0, bt ? b2 : b1};
    assign bus.battingTeam  = bt;
    assign bus.state        = st;
    assign bus.ball_accept  = acc;
    assign bus.winner       = win;
    assign bus.tie          = tie;
    assign bus.winner_valid = wv;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed scoreboard bench for match_controller.
module tb_match_controller;
    logic clk_fpga = 1'b0;
    logic reset = 1'b0;
    always #5 clk_fpga = ~clk_fpga;
    match_controller_if bus();
    match_controller dut (.clk_fpga(clk_fpga), .reset(reset), .bus(bus.slave));
    typedef struct packed {
        logic        tm;
        logic [11:0] d;
        logic [6:0]  b;
        logic [2:0]  st;
    } exp_t;
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int m_st, m_r1, m_w1, m_b1, m_r2, m_w2, m_b2;
    bit m_win, m_tie, m_wv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int s);
        m_st = s; m_r1 = 0; m_w1 = 0; m_b1 = 0; m_r2 = 0; m_w2 = 0; m_b2 = 0;
        m_win = 0; m_tie = 0; m_wv = 0;
    endtask

    task automatic check_all(input string tag);
        bit t;
        t = (m_st == 3 || m_st == 4);
        chk({tag, ":state"}, bus.state, m_st);
        chk({tag, ":team1Data"}, bus.team1Data, {m_r1[7:0], m_w1[3:0]});
        chk({tag, ":team2Data"}, bus.team2Data, {m_r2[7:0], m_w2[3:0]});
        chk({tag, ":team1Balls"}, bus.team1Balls, m_b1);
        chk({tag, ":team2Balls"}, bus.team2Balls, m_b2);
        chk({tag, ":battingTeam"}, bus.battingTeam, t);
        chk({tag, ":wickets"}, bus.wickets, t ? m_w2 : m_w1);
        chk({tag, ":balls"}, bus.balls, t ? m_b2 : m_b1);
        chk({tag, ":ball_accept"}, bus.ball_accept, 0);
        chk({tag, ":winner"}, bus.winner, m_win);
        chk({tag, ":tie"}, bus.tie, m_tie);
        chk({tag, ":winner_valid"}, bus.winner_valid, m_wv);
    endtask

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic ball(input logic [2:0] o);
        exp_t e;
        int r, w, b;
        bit t;
        if (m_st == 1 || m_st == 3) begin
            t = (m_st == 3);
            r = t ? m_r2 : m_r1;
            w = t ? m_w2 : m_w1;
            b = t ? m_b2 : m_b1;
            b++;
            if (o == 3'd7) w++;
            else r = (r + o > 255) ? 255 : r + o;
            if (t) begin
                m_r2 = r; m_w2 = w; m_b2 = b;
                if (w == 10 || b == 120 || r > m_r1) begin
                    m_st = 4; m_win = r > m_r1; m_tie = r == m_r1; m_wv = 1;
                end
            end else begin
                m_r1 = r; m_w1 = w; m_b1 = b;
                if (w == 10 || b == 120) m_st = 2;
            end
            e.tm = t; e.d = {r[7:0], w[3:0]}; e.b = b[6:0]; e.st = m_st[2:0];
            sbq.push_back(e);
        end
        @(negedge clk_fpga);
        bus.ball_valid = 1'b1;
        bus.ball_outcome = o;
        tick();
        bus.ball_valid = 1'b0;
        if (bus.ball_accept && sbq.size() > 0) begin
            e = sbq.pop_front();
            accepts++;
            chk("sb_data", e.tm ? bus.team2Data : bus.team1Data, e.d);
            chk("sb_balls", e.tm ? bus.team2Balls : bus.team1Balls, e.b);
            chk("sb_state", bus.state, e.st);
            chk("sb_bat_wickets", bus.wickets, e.d[3:0]);
            chk("sb_bat_balls", bus.balls, {1'b0, e.b});
            chk("sb_battingTeam", bus.battingTeam, e.st == 3'd3 || e.st == 3'd4);
            chk("sb_winner_valid", bus.winner_valid, m_wv);
        end else if (bus.ball_accept) begin
            chk("spurious_accept", bus.ball_accept, 0);
        end
        chk("sb_pending", sbq.size(), 0);
    endtask

    task automatic start_pulse(input bit with_ball);
        if (m_st == 0) m_st = 1;
        else if (m_st == 2) m_st = 3;
        else if (m_st == 4) model_clear(1);
        @(negedge clk_fpga);
        bus.start = 1'b1;
        bus.ball_valid = with_ball;
        bus.ball_outcome = 3'd3;
        tick();
        bus.start = 1'b0;
        bus.ball_valid = 1'b0;
        check_all("start");
    endtask

    task automatic do_reset();
        @(negedge clk_fpga);
        reset = 1'b0;
        model_clear(0);
        sbq.delete();
        @(negedge clk_fpga);
        reset = 1'b1;
        tick();
        check_all("reset");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.ball_valid = 1'b0;
        bus.ball_outcome = 3'd0;
        model_clear(0);
        #12;
        check_all("por");
        @(negedge clk_fpga);
        reset = 1'b1;
        tick();
        check_all("release");
        ball(3'd4);
        // six fours
        start_pulse(0);
        accepts = 0;
        repeat (6) ball(3'd4);
        chk("six_fours_data", bus.team1Data, 12'h180);
        chk("six_fours_balls", bus.team1Balls, 6);
        chk("six_fours_state", bus.state, 1);
        chk("six_fours_accepts", accepts, 6);
        tick();
        chk("accept_single_cycle", bus.ball_accept, 0);
        start_pulse(0);
        // ten wickets end innings, then team 2 also all out for a tie
        do_reset();
        start_pulse(0);
        repeat (10) ball(3'd7);
        chk("all_out_data", bus.team1Data, 12'h00A);
        chk("all_out_state", bus.state, 2);
        ball(3'd7);
        chk("break_ignored_balls", bus.team1Balls, 10);
        start_pulse(1);
        repeat (10) ball(3'd7);
        chk("inn2_all_out_state", bus.state, 4);
        chk("inn2_all_out_tie", bus.tie, 1);
        ball(3'd2);
        check_all("done_frozen");
        // 120 dot balls then a single wins the chase
        do_reset();
        start_pulse(0);
        repeat (120) ball(3'd0);
        chk("overs_up_state", bus.state, 2);
        chk("overs_up_balls", bus.team1Balls, 120);
        start_pulse(0);
        ball(3'd1);
        chk("chase_state", bus.state, 4);
        chk("chase_winner", bus.winner, 1);
        chk("chase_tie", bus.tie, 0);
        chk("chase_valid", bus.winner_valid, 1);
        // run saturation
        do_reset();
        start_pulse(0);
        accepts = 0;
        repeat (60) ball(3'd6);
        chk("sat_data", bus.team1Data, 12'hFF0);
        chk("sat_balls", bus.team1Balls, 60);
        chk("sat_accepts", accepts, 60);
        // tie on overs, then restart from DONE
        do_reset();
        start_pulse(0);
        repeat (120) ball(3'd0);
        start_pulse(0);
        repeat (120) ball(3'd0);
        chk("tie_state", bus.state, 4);
        chk("tie_tie", bus.tie, 1);
        chk("tie_winner", bus.winner, 0);
        start_pulse(0);
        chk("restart_team1Data", bus.team1Data, 0);
        chk("restart_team2Balls", bus.team2Balls, 0);
        chk("restart_state", bus.state, 1);
        // asynchronous reset mid second innings
        do_reset();
        start_pulse(0);
        ball(3'd6);
        repeat (10) ball(3'd7);
        start_pulse(0);
        ball(3'd3);
        chk("pre_async_state", bus.state, 3);
        #2;
        reset = 1'b0;
        model_clear(0);
        #1;
        check_all("async_immediate");
        bus.start = 1'b1;
        bus.ball_valid = 1'b1;
        bus.ball_outcome = 3'd4;
        tick();
        check_all("held_in_reset");
        bus.start = 1'b0;
        bus.ball_valid = 1'b0;
        @(negedge clk_fpga);
        reset = 1'b1;
        tick();
        check_all("after_async_release");
        ball(3'd4);
        start_pulse(0);
        ball(3'd4);
        chk("resume_data", bus.team1Data, 12'h040);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
